// File: rtl/rot_job_sched.sv
// rot_job_sched: round-robin job scheduler in front of a shared 4-bit
// load/rotate datapath.
//
// One job is in flight at a time. The winning requester's operand and mode
// are latched, the mode is translated into the datapath {a,b} controls and
// start is pulsed. The result comes back on rsp_*. A watchdog resets the
// datapath and reports an error if ready never arrives.
//
// Handshakes:
//   req/gnt  : a requester holds req[i] (with its req_x/req_mode fields
//              stable) until it sees gnt[i]. gnt is a one-cycle, one-hot
//              accept pulse. A req still high in a later IDLE cycle is a new
//              job. req changes while busy are ignored.
//   rsp      : rsp_valid is a one-cycle pulse with no back-pressure. rsp_id,
//              rsp_data and rsp_err are meaningful only while rsp_valid=1.
//   datapath : dp_start is a one-cycle pulse. dp_z is sampled only while
//              dp_ready=1 in WAIT.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-low reset
//   req, req_x, req_mode per-requester request, 4-bit operand, 2-bit mode
//   gnt                  one-hot accept pulse
//   busy                 high in every state except IDLE
//   rsp_valid/id/data/err  result pulse, one-hot owner, value, error flag
//   dp_rst               active-high datapath reset (combinational)
//   dp_start, dp_a, dp_b, dp_x   datapath controls and operand
//   dp_ready, dp_z       datapath done flag and result
//   dbg_state            current FSM state (IDLE=0 LAUNCH=1 WAIT=2 FLUSH=3 RESP=4)

module rot_job_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_x,
    input  logic [2*NREQ-1:0] req_mode,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [NREQ-1:0]   rsp_id,
    output logic [3:0]        rsp_data,
    output logic              rsp_err,
    output logic              dp_rst,
    output logic              dp_start,
    output logic              dp_a,
    output logic              dp_b,
    output logic [3:0]        dp_x,
    input  logic              dp_ready,
    input  logic [3:0]        dp_z,
    output logic [2:0]        dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FLUSH  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] id_q, id_d;
    logic [3:0]      x_q, x_d;
    logic [1:0]      ab_q, ab_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0]      res_q, res_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] gnt_d;
    logic            busy_d;
    logic            rsp_valid_d;
    logic [NREQ-1:0] rsp_id_d;
    logic [3:0]      rsp_data_d;
    logic            rsp_err_d;
    logic            dp_start_d;
    logic            dp_a_d;
    logic            dp_b_d;
    logic [3:0]      dp_x_d;
    logic            dp_on;

    // Arbitration: "hi" is the first request strictly above the pointer,
    // "lo" the first request overall. If nothing sits above the pointer the
    // search wraps, and the first overall request is then the right winner.
    logic            hi_found, lo_found, arb_found;
    logic [IW-1:0]   hi_id, lo_id, arb_id;
    logic [3:0]      hi_x, lo_x, arb_x;
    logic [1:0]      hi_mode, lo_mode, arb_mode;
    logic [NREQ-1:0] arb_oh;
    logic [1:0]      arb_ab;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_x     = '0;
        lo_x     = '0;
        hi_mode  = '0;
        lo_mode  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (IW'(i) > ptr_q) && !hi_found) begin
                hi_found = 1'b1;
                hi_id    = IW'(i);
                hi_x     = req_x[4*i +: 4];
                hi_mode  = req_mode[2*i +: 2];
            end
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = IW'(i);
                lo_x     = req_x[4*i +: 4];
                lo_mode  = req_mode[2*i +: 2];
            end
        end
        arb_found = hi_found | lo_found;
        arb_id    = hi_found ? hi_id   : lo_id;
        arb_x     = hi_found ? hi_x    : lo_x;
        arb_mode  = hi_found ? hi_mode : lo_mode;
        arb_oh         = '0;
        arb_oh[arb_id] = 1'b1;
        // {a,b}=00 would park the datapath in its load state, so the three
        // legal modes map onto the three non-zero control codes.
        unique case (arb_mode)
            2'b00:   arb_ab = 2'b01;
            2'b01:   arb_ab = 2'b10;
            2'b10:   arb_ab = 2'b11;
            default: arb_ab = 2'b00;
        endcase
    end

    // Next-state and next-output logic. Every output except dp_rst is a
    // register loaded from the *_d value on the edge that enters the state.
    // rsp_* are loaded on the edge leaving RESP, so the result pulse sits in
    // the following IDLE cycle; that keeps it clear of the gnt pulse of a
    // mode-11 job, which goes straight from IDLE to RESP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        x_d         = x_q;
        ab_d        = ab_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        err_d       = err_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    ptr_d = arb_id;
                    id_d  = arb_oh;
                    gnt_d = arb_oh;
                    x_d   = arb_x;
                    ab_d  = arb_ab;
                    if (arb_mode == 2'b11) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready wins over the watchdog, so ready on the last allowed
                // cycle still completes the job.
                if (dp_ready) begin
                    res_d   = dp_z;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = res_q;
                rsp_err_d   = err_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        dp_start_d = (state_d == LAUNCH);
        dp_on      = (state_d == LAUNCH) || (state_d == WAIT);
        dp_x_d     = dp_on ? x_d : 4'h0;
        dp_a_d     = dp_on & ab_d[1];
        dp_b_d     = dp_on & ab_d[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            id_q      <= '0;
            x_q       <= '0;
            ab_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            dp_start  <= 1'b0;
            dp_a      <= 1'b0;
            dp_b      <= 1'b0;
            dp_x      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            x_q       <= x_d;
            ab_q      <= ab_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            err_q     <= err_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            dp_start  <= dp_start_d;
            dp_a      <= dp_a_d;
            dp_b      <= dp_b_d;
            dp_x      <= dp_x_d;
        end
    end

    // The datapath is held in reset alongside the scheduler and for the
    // single FLUSH cycle after a watchdog expiry.
    assign dp_rst    = ~rst | (state_q == FLUSH);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rot_job_sched.sv
module tb_rot_job_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd2;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [15:0]     req_x;
    logic [7:0]      req_mode;
    logic [3:0]      gnt;
    logic            busy;
    logic            rsp_valid;
    logic [3:0]      rsp_id;
    logic [3:0]      rsp_data;
    logic            rsp_err;
    logic            dp_rst;
    logic            dp_start;
    logic            dp_a;
    logic            dp_b;
    logic [3:0]      dp_x;
    logic            dp_ready;
    logic [3:0]      dp_z;
    logic [2:0]      dbg_state;

    rot_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .req_mode  (req_mode),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dp_rst    (dp_rst),
        .dp_start  (dp_start),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_x      (dp_x),
        .dp_ready  (dp_ready),
        .dp_z      (dp_z),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    logic [8:0] exp_q[$];      // {rsp_id, rsp_data, rsp_err}
    logic [3:0] gnt_exp_q[$];
    logic [1:0] ab_exp_q[$];
    logic [3:0] dx_exp_q[$];
    logic [8:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_rot(input logic [3:0] x, input logic [1:0] m);
        case (m)
            2'b00:   return x;
            2'b01:   return {x[0], x[3:1]};
            2'b10:   return {x[1:0], x[3:2]};
            default: return 4'h0;
        endcase
    endfunction

    task automatic push_exp(input int id, input logic [3:0] x, input logic [1:0] m, input bit will_timeout);
        logic [3:0] oh;
        logic [1:0] ab;
        oh = 4'b0001 << id;
        gnt_exp_q.push_back(oh);
        if (m != 2'b11) begin
            case (m)
                2'b00:   ab = 2'b01;
                2'b01:   ab = 2'b10;
                default: ab = 2'b11;
            endcase
            ab_exp_q.push_back(ab);
            dx_exp_q.push_back(x);
        end
        if (m == 2'b11 || will_timeout) exp_q.push_back({oh, 4'h0, 1'b1});
        else                            exp_q.push_back({oh, ref_rot(x, m), 1'b0});
    endtask

    // ---------------- datapath model ----------------
    // Updates on the falling edge; {a,b}: 01 load/pass, 10 ror1, 11 ror2.
    bit         dp_hang = 1'b0;
    int         dp_lat_force = -1;
    bit         dp_run = 1'b0;
    int         dp_cnt = 0;
    logic [3:0] dp_reg = 4'h0;
    logic [1:0] dp_ab = 2'b00;

    initial begin
        dp_ready = 1'b0;
        dp_z     = 4'h0;
    end

    always @(negedge clk) begin
        if (dp_rst) begin
            dp_ready = 1'b0;
            dp_run   = 1'b0;
            dp_reg   = 4'h0;
        end else if (dp_start) begin
            dp_reg   = dp_x;
            dp_ab    = {dp_a, dp_b};
            dp_ready = 1'b0;
            dp_run   = !dp_hang;
            dp_cnt   = (dp_lat_force >= 0) ? dp_lat_force : int'($urandom_range(0, 6));
        end else if (dp_run) begin
            if (dp_cnt == 0) begin
                case (dp_ab)
                    2'b01:   dp_reg = dp_reg;
                    2'b10:   dp_reg = {dp_reg[0], dp_reg[3:1]};
                    2'b11:   dp_reg = {dp_reg[1:0], dp_reg[3:2]};
                    default: dp_reg = 4'h0;
                endcase
                dp_ready = 1'b1;
                dp_run   = 1'b0;
            end else begin
                dp_cnt--;
            end
        end
        // Garbage on dp_z whenever it is not qualified by ready.
        dp_z = dp_ready ? dp_reg : 4'($urandom_range(0, 15));
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (dp_start) begin
            start_cnt++;
            if (ab_exp_q.size() == 0) check("dp_start_unexpected", 1, 0);
            else begin
                check("dp_ab", {dp_a, dp_b}, ab_exp_q.pop_front());
                check("dp_x", dp_x, dx_exp_q.pop_front());
            end
        end
        if (gnt != 4'b0000) begin
            if (gnt_exp_q.size() == 0) check("gnt_unexpected", gnt, 0);
            else                       check("gnt", gnt, gnt_exp_q.pop_front());
        end
        if (rsp_valid) begin
            check("gnt_during_rsp", gnt, 0);
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", rsp_id, mon_e[8:5]);
                check("rsp_data", rsp_data, mon_e[4:1]);
                check("rsp_err", rsp_err, mon_e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input int id, input logic [3:0] x, input logic [1:0] m,
                           input bit hang, input int lat);
        bit seen;
        int n_wait;
        int s0;
        @(negedge clk);
        dp_hang      = hang;
        dp_lat_force = lat;
        req_x[4*id +: 4]  = x;
        req_mode[2*id +: 2] = m;
        push_exp(id, x, m, hang);
        s0 = start_cnt;
        req[id] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (gnt[id]) seen = 1'b1;
        end
        req[id] = 1'b0;
        if (!seen) check("gnt_wait", 0, 1);
        if (hang) begin
            seen   = 1'b0;
            n_wait = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (dp_rst) seen = 1'b1;
                else        n_wait++;
            end
            check("flush_seen", seen, 1);
            check("wait_cycles", n_wait, TIMEOUT);
            @(negedge clk);
            check("dp_rst_width", dp_rst, 0);
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("rsp_wait", 0, 1);
        check("dp_start_pulses", start_cnt - s0, (m == 2'b11) ? 0 : 1);
        dp_hang      = 1'b0;
        dp_lat_force = -1;
    endtask

    // Requesters drop req on gnt; those flagged in extra_in re-request once
    // right after their own response.
    task automatic run_batch(input logic [3:0] extra_in, input int n_rsp);
        logic [3:0] extra;
        int got;
        extra = extra_in;
        got   = 0;
        for (int n = 0; n < 400 && got < n_rsp; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) req[i] = 1'b0;
                if (rsp_valid && rsp_id[i]) begin
                    got++;
                    if (extra[i]) begin
                        req[i]   = 1'b1;
                        extra[i] = 1'b0;
                    end
                end
            end
        end
        check("batch_rsp_count", got, n_rsp);
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] rr_x [4];
    logic [1:0] rr_m [4];

    initial begin
        rst      = 1'b0;
        req      = 4'b0000;
        req_x    = 16'h0;
        req_mode = 8'h0;

        // Reset with every requester asking; nothing may be granted.
        rr_x[0] = 4'b1011; rr_m[0] = 2'b00;
        rr_x[1] = 4'b0110; rr_m[1] = 2'b01;
        rr_x[2] = 4'b1001; rr_m[2] = 2'b10;
        rr_x[3] = 4'b0011; rr_m[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_x[4*i +: 4]   = rr_x[i];
            req_mode[2*i +: 2] = rr_m[i];
        end
        req = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_dp_rst", dp_rst, 1);
            check("rst_busy", busy, 0);
        end

        // Round robin straight out of reset: 0,1,2,3 then 0 again.
        for (int i = 0; i < 4; i++) push_exp(i, rr_x[i], rr_m[i], 1'b0);
        push_exp(0, rr_x[0], rr_m[0], 1'b0);
        rst = 1'b1;
        run_batch(4'b0001, 5);

        // Single job and the mode table.
        run_job(2, 4'b1011, 2'b01, 1'b0, -1);
        run_job(1, 4'b1011, 2'b00, 1'b0, -1);
        run_job(3, 4'b1011, 2'b10, 1'b0, -1);
        run_job(0, 4'b1011, 2'b11, 1'b0, -1);

        // Ready on the last allowed WAIT cycle still succeeds.
        run_job(2, 4'b0110, 2'b01, 1'b0, TIMEOUT - 1);

        // Watchdog expiry, then a normal job on the same requester.
        run_job(1, 4'b1111, 2'b00, 1'b1, -1);
        run_job(1, 4'b1000, 2'b10, 1'b0, -1);

        // Reset in the middle of a job.
        @(negedge clk);
        dp_hang = 1'b1;
        req_x[3:0]    = 4'b0111;
        req_mode[1:0] = 2'b01;
        push_exp(0, 4'b0111, 2'b01, 1'b0);
        req[0] = 1'b1;
        begin : mid_gnt
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (gnt[0]) seen = 1'b1;
            end
            if (!seen) check("mid_gnt_wait", 0, 1);
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_state_wait", dbg_state, ST_WAIT);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_dp_rst", dp_rst, 1);
        end
        rst     = 1'b1;
        dp_hang = 1'b0;
        @(negedge clk);
        check("post_rst_state", dbg_state, ST_IDLE);
        check("post_rst_rsp", rsp_valid, 0);

        // Pointer must be back at NREQ-1: requester 0 beats requester 3.
        req_x[3:0]     = 4'b0001;
        req_mode[1:0]  = 2'b01;
        req_x[15:12]   = 4'b1100;
        req_mode[7:6]  = 2'b00;
        push_exp(0, 4'b0001, 2'b01, 1'b0);
        push_exp(3, 4'b1100, 2'b00, 1'b0);
        req = 4'b1001;
        run_batch(4'b0000, 2);

        // Random jobs.
        for (int k = 0; k < 8; k++) begin
            run_job(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'b0, -1);
        end

        repeat (4) @(negedge clk);
        check("exp_q_left", exp_q.size(), 0);
        check("gnt_q_left", gnt_exp_q.size(), 0);
        check("ab_q_left", ab_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rot_job_sched.md
Name: rot_job_sched

Overview:
Round-robin scheduler that shares one 4-bit load/rotate datapath (start/a/b/x in, ready/z out) among NREQ requesters. It accepts one job at a time, maps the job mode to the datapath a/b controls, and pulses start. It then waits for ready, captures z and returns the result to the winning requester. A watchdog recovers the datapath if ready never arrives.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 15, max WAIT cycles before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
req  in  NREQ  per-requester job request, held until gnt
req_x  in  4*NREQ  operand, requester i at bits [4i+3:4i]
req_mode  in  2*NREQ  mode, requester i at [2i+1:2i]; 00 pass, 01 rotate-right-1, 10 rotate-right-2, 11 reserved
gnt  out  NREQ  one-hot, 1-cycle accept pulse
busy  out  1  high in any state except IDLE
rsp_valid  out  1  1-cycle result pulse
rsp_id  out  NREQ  one-hot owner of rsp
rsp_data  out  4  result
rsp_err  out  1  result invalid (reserved mode or timeout)
dp_rst  out  1  active-high datapath reset
dp_start  out  1  datapath start
dp_a  out  1  datapath a control
dp_b  out  1  datapath b control
dp_x  out  4  datapath operand
dp_ready  in  1  datapath done
dp_z  in  4  datapath result, valid while dp_ready=1

Behaviour:
- States: IDLE, LAUNCH, WAIT, FLUSH, RESP. All outputs registered except dp_rst.
- Reset (rst=0 at clk edge): state=IDLE, rr pointer=NREQ-1 (req[0] wins first), all outputs 0. dp_rst = ~rst | (state==FLUSH), so the datapath is held in reset while rst=0.
- Reset mid-job aborts the job. No rsp is issued. The job is lost.
- IDLE: if |req, pick the first set bit searching from (ptr+1) mod NREQ upward with wrap. On that edge, latch id, x and mode, set ptr=id, and set gnt[id]=1 for exactly one cycle.
  - mode 11: go to RESP with rsp_err=1 and rsp_data=0. No datapath activity.
  - Other modes: go to LAUNCH.
- Mode map {dp_a,dp_b}: 00->01, 01->10, 10->11. {a,b}=00 is never driven (it would stall the datapath in its load state).
- dp_x, dp_a and dp_b hold the latched values from LAUNCH through WAIT. They are 0 in IDLE.
- LAUNCH: dp_start=1 for one cycle, then WAIT. The watchdog counter is cleared.
- WAIT: dp_start=0.
  - If dp_ready=1: capture dp_z into rsp_data, rsp_err=0, go to RESP.
  - Else counter++. When TIMEOUT cycles elapse without ready, go to FLUSH.
  - dp_ready seen on the last allowed cycle counts as success.
- FLUSH: dp_rst=1 for one cycle, then RESP with rsp_err=1 and rsp_data=0.
- RESP: rsp_valid=1 and rsp_id=latched one-hot for one cycle, then IDLE.
- Only one job is in flight. The next arbitration happens in the IDLE cycle after RESP, with minimum 1 IDLE cycle between jobs.
- req toggling while busy is ignored.
- gnt and rsp_valid never coincide.
- Requesters drop req on gnt. A req still high in the next IDLE is treated as a new job.
- The datapath updates its register on the falling clock edge. dp_z is sampled only while dp_ready=1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=1111 -> gnt=0, rsp_valid=0, dp_rst=1, busy=0; after release, req[0] granted first.
- Single job: req[2], x=1011, mode 01 -> gnt=0100; dp_start one pulse with {a,b}=10; rsp_valid, rsp_id=0100, rsp_data=1101, rsp_err=0.
- Modes: x=1011 -> mode 00 gives 1011, mode 10 gives 1110. Mode 11 gives rsp_err=1, data 0000, and dp_start never asserts.
- Round robin: req=1111 held, each requester re-requesting after its own rsp -> grant order 0001, 0010, 0100, 1000, 0001; no requester granted twice before all others are served.
- Timeout: datapath model never raises ready, TIMEOUT=15 -> exactly 15 WAIT cycles, then dp_rst one cycle, then rsp_err=1, then the next job completes normally.
- Reset mid-job: rst=0 during WAIT -> no rsp_valid, state IDLE, ptr reset; a fresh request is serviced correctly.
